// File: rtl/rvb_bmat_opq.sv
// Operand queue feeding the bit-matrix unit: DEPTH-entry registered FIFO that
// carries rs1/rs2/insn30/tag from the issue stage to the unit's din_* port.
module rvb_bmat_opq #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAGW  = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [63:0]                  in_rs1,
  input  logic [63:0]                  in_rs2,
  input  logic                         in_insn30,
  input  logic [TAGW-1:0]              in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_rs1,
  output logic [63:0]                  out_rs2,
  output logic                         out_insn30,
  output logic [TAGW-1:0]              out_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0]     rs1;
    logic [63:0]     rs2;
    logic            insn30;
    logic [TAGW-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  entry_t        head;

  // Handshakes; a flush cancels the pop and in_ready already blocks the push.
  always_comb begin
    in_ready  = (cnt != CW'(DEPTH)) && !flush && reset;
    out_valid = (cnt != '0) && reset;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready && !flush;
  end

  // Head presentation; zeros whenever the queue is empty or in reset.
  always_comb begin
    head       = mem[rd_ptr];
    out_rs1    = '0;
    out_rs2    = '0;
    out_insn30 = 1'b0;
    out_tag    = '0;
    if (out_valid) begin
      out_rs1    = head.rs1;
      out_rs2    = head.rs2;
      out_insn30 = head.insn30;
      out_tag    = head.tag;
    end
  end

  // Entry storage; intentionally not reset, only occupancy state is.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{rs1: in_rs1, rs2: in_rs2, insn30: in_insn30, tag: in_tag};
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;

endmodule

// File: tb/tb_rvb_bmat_opq.sv
// Scoreboard bench for rvb_bmat_opq: the driver queues expected entries on
// accept, a negedge monitor checks handshakes/occupancy/head and pops on output.
module tb_rvb_bmat_opq;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAGW  = 5;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0]     rs1;
    logic [63:0]     rs2;
    logic            insn30;
    logic [TAGW-1:0] tag;
  } ent_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [63:0]     in_rs1 = '0;
  logic [63:0]     in_rs2 = '0;
  logic            in_insn30 = 1'b0;
  logic [TAGW-1:0] in_tag = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [63:0]     out_rs1;
  logic [63:0]     out_rs2;
  logic            out_insn30;
  logic [TAGW-1:0] out_tag;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;

  ent_t            sb[$];
  logic [TAGW-1:0] exits[$];
  logic            acc;

  rvb_bmat_opq #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_insn30(in_insn30), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_insn30(out_insn30), .out_tag(out_tag),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy/handshake checks against the scoreboard, head compare, pop.
  always @(negedge clock) begin
    chk("count", 64'(count), 64'(sb.size()));
    chk("count_max", 64'(count <= CW'(DEPTH)), 64'd1);
    chk("out_valid", 64'(out_valid), 64'((sb.size() != 0) && reset));
    chk("in_ready", 64'(in_ready), 64'((sb.size() != DEPTH) && !flush && reset));
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("head_present", 64'd0, 64'd1);
      end else begin
        chk("out_rs1", out_rs1, sb[0].rs1);
        chk("out_rs2", out_rs2, sb[0].rs2);
        chk("out_insn30", 64'(out_insn30), 64'(sb[0].insn30));
        chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
        if (out_ready && !flush && reset) begin
          exits.push_back(out_tag);
          void'(sb.pop_front());
        end
      end
    end else begin
      chk("idle_zero", 64'(out_rs1 | out_rs2 | 64'(out_insn30) | 64'(out_tag)), 64'd0);
    end
  end

  // One clock of stimulus; expected entry is queued when the push is accepted.
  task automatic cycle(input logic iv, input logic [63:0] a, input logic [63:0] b,
                       input logic x, input logic [TAGW-1:0] t, input logic ordy,
                       input logic fl, output logic accepted);
    @(posedge clock);
    #1;
    in_valid = iv; in_rs1 = a; in_rs2 = b; in_insn30 = x; in_tag = t;
    out_ready = ordy; flush = fl;
    @(negedge clock);
    #1;
    accepted = iv && in_ready;
    if (fl) sb.delete();
    else if (accepted) sb.push_back('{rs1: a, rs2: b, insn30: x, tag: t});
  endtask

  task automatic push_tag(input logic [TAGW-1:0] t, input logic ordy, output logic accepted);
    cycle(1'b1, {59'h0, t} * 64'h9E37_79B9_7F4A_7C15, ~{59'h0, t}, t[0], t, ordy, 1'b0, accepted);
  endtask

  task automatic drain();
    logic a;
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, a);
      n++;
    end
    chk("drain_bound", 64'(sb.size()), 64'd0);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, a);
  endtask

  task automatic chk_exits(input string name, input logic [TAGW-1:0] exp[$]);
    chk({name, "_len"}, 64'(exits.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < exits.size(); i++)
      chk(name, 64'(exits[i]), 64'(exp[i]));
    exits.delete();
  endtask

  initial begin
    logic [TAGW-1:0] e[$];
    int n;

    repeat (2) @(negedge clock);
    #2 reset = 1'b1;

    // 1: single push with out_ready held high.
    cycle(1'b1, 64'h0102040810204080, 64'h8040201008040201, 1'b1, 5'd3, 1'b1, 1'b0, acc);
    chk("t1_accept", 64'(acc), 64'd1);
    chk("t1_cnt_pre", 64'(count), 64'd0);
    chk("t1_ov_pre", 64'(out_valid), 64'd0);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("t1_cnt1", 64'(count), 64'd1);
    chk("t1_ov1", 64'(out_valid), 64'd1);
    chk("t1_rs1", out_rs1, 64'h0102040810204080);
    chk("t1_rs2", out_rs2, 64'h8040201008040201);
    chk("t1_insn30", 64'(out_insn30), 64'd1);
    chk("t1_tag", 64'(out_tag), 64'd3);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("t1_cnt0", 64'(count), 64'd0);
    e = '{5'd3};
    chk_exits("t1_exits", e);

    // 2: backpressure on a full queue, then release.
    push_tag(5'd1, 1'b0, acc);
    push_tag(5'd2, 1'b0, acc);
    push_tag(5'd3, 1'b0, acc);
    chk("t2_full_cnt", 64'(count), 64'd2);
    chk("t2_full_rdy", 64'(in_ready), 64'd0);
    chk("t2_held", 64'(acc), 64'd0);
    n = 0;
    do begin
      push_tag(5'd3, 1'b1, acc);
      n++;
    end while (!acc && n < 10);
    chk("t2_tag3_accept", 64'(acc), 64'd1);
    drain();
    e = '{5'd1, 5'd2, 5'd3};
    chk_exits("t2_exits", e);

    // 3: steady push+pop at count=1 through pointer wrap.
    push_tag(5'd0, 1'b0, acc);
    for (int i = 1; i <= 9; i++) begin
      push_tag(5'(i), 1'b1, acc);
      chk("t3_cnt", 64'(count), 64'd1);
      chk("t3_accept", 64'(acc), 64'd1);
    end
    drain();
    e = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    chk_exits("t3_exits", e);

    // 4: flush on a full queue with a simultaneous incoming operand.
    push_tag(5'd10, 1'b0, acc);
    push_tag(5'd11, 1'b0, acc);
    cycle(1'b1, 64'hDEAD, 64'hBEEF, 1'b0, 5'd12, 1'b0, 1'b1, acc);
    chk("t4_flush_rdy", 64'(in_ready), 64'd0);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("t4_cnt", 64'(count), 64'd0);
    chk("t4_ov", 64'(out_valid), 64'd0);
    drain();
    e = {};
    chk_exits("t4_exits", e);

    // 5: asynchronous reset between edges with a full queue.
    push_tag(5'd20, 1'b0, acc);
    push_tag(5'd21, 1'b0, acc);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, acc);
    chk("t5_full", 64'(count), 64'd2);
    @(posedge clock);
    #3 reset = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_ov", 64'(out_valid), 64'd0);
    chk("t5_rst_rdy", 64'(in_ready), 64'd0);
    chk("t5_rst_cnt", 64'(count), 64'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    push_tag(5'd7, 1'b0, acc);
    chk("t5_accept", 64'(acc), 64'd1);
    cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, acc);
    chk("t5_ov", 64'(out_valid), 64'd1);
    chk("t5_tag", 64'(out_tag), 64'd7);
    drain();
    e = '{5'd7};
    chk_exits("t5_exits", e);

    // 6: random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), acc);
    end
    drain();
    exits.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
